hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS32 core. Drives the write-enable and flush (bubble) controls of the PC, IF/ID and ID/EX pipeline registers. It resolves load-use hazards, taken branch/jump redirects and multi-cycle mult/div occupancy. It also keeps saturating stall and flush statistics counters for performance debug.

## Interface
Parameters:
- MD_LATENCY, 32, total cycles a mult/div occupies EX (legal range 2..63)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- id_rs  input  5  rs field of the instruction in ID
- id_rt  input  5  rt field of the instruction in ID
- id_uses_rt  input  1  ID instruction reads rt
- id_md_start  input  1  ID instruction is mult/div
- ex_MemRead  input  1  MemRead of the instruction in EX (ID/EX output)
- ex_rt  input  5  inst20_16 of the instruction in EX (load destination)
- ex_branch_taken  input  1  branch in EX resolved taken
- ex_jump  input  1  jump in EX
- stat_clr  input  1  synchronous clear of both statistics counters
- pc_write  output  1  PC load enable
- if_id_write  output  1  IF/ID load enable
- if_id_flush  output  1  load IF/ID with NOP
- id_ex_flush  output  1  load ID/EX with zeroed control (bubble)
- md_busy  output  1  mult/div occupying EX (registered state)
- md_done  output  1  one-cycle pulse in the final MD_WAIT cycle
- stall_cycles  output  32  saturating count of cycles with pc_write=0
- flush_count  output  16  saturating count of redirect events

## Operation
- States: RUN, MD_WAIT. The 6-bit down-counter md_cnt is reset to 0.
- Control outputs are combinational from state and inputs. Priority in RUN, highest first:
  1. Redirect (ex_branch_taken | ex_jump): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1. id_md_start is ignored.
  2. Load-use: ex_MemRead & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)). Outputs pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0. id_md_start is ignored; the instruction is held in ID and retries next cycle.
  3. id_md_start: normal outputs (pc_write=1, if_id_write=1, no flush). Next state is MD_WAIT and md_cnt loads MD_LATENCY-1.
  4. Otherwise: pc_write=1, if_id_write=1, flushes 0.
- MD_WAIT: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, md_busy=1. md_cnt decrements each cycle.
  - When md_cnt==1: md_done=1 and next state is RUN.
  - Redirect and load-use inputs are ignored; they cannot legally occur here.
- A load-use match with ex_rt==0 never stalls.
- stall_cycles increments on every cycle with pc_write=0 and saturates at 0xFFFFFFFF.
- flush_count increments on every cycle with if_id_flush=1 and saturates at 0xFFFF.
- stat_clr takes priority over increment; the counter value becomes 0 on the next edge.

## Timing
- Reset values: state=RUN, md_cnt=0, md_busy=0, md_done=0, stall_cycles=0, flush_count=0.
- With idle inputs after reset: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0.
- Control outputs react in the same cycle as the inputs (Mealy). The pipeline registers sample them on the next rising edge.
- Load-use costs exactly 1 stall cycle: the load leaves EX at the next edge and the match clears.
- Mult/div accepted in cycle T: MD_WAIT covers cycles T+1..T+MD_LATENCY-1, md_done is high in cycle T+MD_LATENCY-1, and the state is RUN in cycle T+MD_LATENCY.
  - Stall cycles = MD_LATENCY-1.
- Back-to-back mult/div: the second instruction is in ID when RUN resumes. It is accepted immediately if no higher-priority event is present.
- Reset asserted mid-MD_WAIT: the state returns to RUN asynchronously and md_busy drops immediately. No md_done is issued.
- Statistics counters update on clock edges only. Their increment conditions use the combinational outputs of that cycle.

## Test plan
- Reset release, idle inputs -> pc_write=1, if_id_write=1, both flushes 0, stall_cycles=0, flush_count=0.
- ex_MemRead=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for 1 cycle; stall_cycles=1. Repeat with ex_rt=0 -> no stall.
- ex_branch_taken=1 together with a load-use match and id_md_start=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1, state stays RUN, flush_count=1.
- MD_LATENCY=4, id_md_start pulse at T -> md_busy=1 in T+1..T+3, md_done only in T+3, pc_write=0 for 3 cycles, RUN at T+4, stall_cycles=3.
- Load-use and id_md_start in the same cycle -> load-use stall with no MD_WAIT entry. Next cycle without the hazard -> MD_WAIT entered.
- reset_n low in the second MD_WAIT cycle -> md_busy=0 immediately, no md_done. Then hold the stall condition for 2^32+ cycles (forced counter preload) -> stall_cycles saturates at 0xFFFFFFFF. stat_clr -> 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/sequencing controller with stall and flush statistics
module hazard_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_md_start,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        ex_jump,
  input  logic        stat_clr,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // Counter starts at LATENCY-1 so the final wait cycle is the one where it reads 1.
  localparam logic [5:0] MD_CNT_LOAD = 6'(MD_LATENCY - 1);
  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;
  localparam logic [15:0] FLUSH_MAX = 16'hFFFF;

  state_t      state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic        redirect;
  logic        load_use;

  // Hazard detection; a load into $zero never creates a dependency.
  always_comb begin
    redirect = ex_branch_taken | ex_jump;
    load_use = ex_MemRead && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  // Mealy control outputs and next-state selection.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    case (state_q)
      RUN: begin
        if (redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else if (id_md_start) begin
          state_d  = MD_WAIT;
          md_cnt_d = MD_CNT_LOAD;
        end
      end
      MD_WAIT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        md_busy     = 1'b1;
        md_cnt_d    = md_cnt_q - 6'd1;
        if (md_cnt_q == 6'd1) begin
          md_done = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = 6'd0;
      end
    endcase
  end

  // Saturating statistics; clear wins over increment.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stat_clr) begin
      stall_cycles_d = 32'd0;
      flush_count_d  = 16'd0;
    end else begin
      if (!pc_write && (stall_cycles_q != STALL_MAX)) begin
        stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (if_id_flush && (flush_count_q != FLUSH_MAX)) begin
        flush_count_d = flush_count_q + 16'd1;
      end
    end
  end

  // State, mult/div counter and statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      md_cnt_q       <= 6'd0;
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 0, id_md_start = 0, ex_MemRead = 0;
  logic        ex_branch_taken = 0, ex_jump = 0, stat_clr = 0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, md_done;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  hazard_ctrl #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_md_start(id_md_start), .ex_MemRead(ex_MemRead),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .stat_clr(stat_clr), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .md_busy(md_busy),
    .md_done(md_done), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Staged stimulus, applied at the next falling edge
  logic [4:0] s_rs = '0, s_rt = '0, s_ex_rt = '0;
  logic s_uses_rt = 0, s_md = 0, s_mr = 0, s_br = 0, s_j = 0, s_clr = 0;

  // Behavioural model: remaining mult/div busy cycles and plain counters
  int     busy_left = 0;
  longint m_stall = 0;
  int     m_flush = 0;
  bit     e_pc, e_ifw, e_iff, e_idf, e_busy, e_done;

  // Preload requests
  bit     pre_stall = 0, pre_flush = 0;
  logic [31:0] pre_stall_v = '0;
  logic [15:0] pre_flush_v = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_idle();
    s_rs = 0; s_rt = 0; s_ex_rt = 0; s_uses_rt = 0; s_md = 0;
    s_mr = 0; s_br = 0; s_j = 0; s_clr = 0;
  endtask

  task automatic model_reset();
    busy_left = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_eval();
    bit redir, lu;
    redir = s_br || s_j;
    lu = s_mr && (s_ex_rt != 0) && (s_ex_rt == s_rs || (s_uses_rt && s_ex_rt == s_rt));
    e_busy = busy_left > 0;
    e_done = busy_left == 1;
    if (busy_left > 0) begin
      e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 1;
    end else if (redir) begin
      e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 1;
    end else begin
      e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0;
    end
    // Next-cycle model state
    if (busy_left > 0) busy_left--;
    else if (!redir && !lu && s_md) busy_left = LAT - 1;
  endtask

  task automatic model_count();
    if (s_clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e_iff && m_flush < 16'hFFFF) m_flush++;
    end
  endtask

  // One clock cycle: drive at falling edge, compare everything, advance model
  task automatic step();
    @(negedge clk);
    cyc++;
    id_rs = s_rs; id_rt = s_rt; ex_rt = s_ex_rt; id_uses_rt = s_uses_rt;
    id_md_start = s_md; ex_MemRead = s_mr; ex_branch_taken = s_br;
    ex_jump = s_j; stat_clr = s_clr;
    if (pre_stall) begin
      force dut.stall_cycles_q = pre_stall_v;
      m_stall = pre_stall_v;
    end
    if (pre_flush) begin
      force dut.flush_count_q = pre_flush_v;
      m_flush = pre_flush_v;
    end
    #1;
    if (pre_stall) release dut.stall_cycles_q;
    if (pre_flush) release dut.flush_count_q;
    pre_stall = 0; pre_flush = 0;
    #1;
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
    model_eval();
    chk("pc_write", pc_write, e_pc);
    chk("if_id_write", if_id_write, e_ifw);
    chk("if_id_flush", if_id_flush, e_iff);
    chk("id_ex_flush", id_ex_flush, e_idf);
    chk("md_busy", md_busy, e_busy);
    chk("md_done", md_done, e_done);
    model_count();
  endtask

  initial begin
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    model_reset();

    // Reset state with idle inputs
    step();
    chk("rst_pc_lit", pc_write, 1);
    chk("rst_iff_lit", if_id_flush, 0);
    chk("rst_stall_lit", stall_cycles, 0);
    chk("rst_flush_lit", flush_count, 0);

    // Load-use on rs, one stall cycle
    s_mr = 1; s_ex_rt = 5; s_rs = 5;
    step();
    chk("lu_pc_lit", pc_write, 0);
    chk("lu_idf_lit", id_ex_flush, 1);
    set_idle();
    step();
    chk("lu_stall_lit", stall_cycles, 1);
    chk("lu_release_pc_lit", pc_write, 1);
    // Load into $zero never stalls
    s_mr = 1; s_ex_rt = 0; s_rs = 0;
    step();
    chk("lu_r0_pc_lit", pc_write, 1);
    set_idle();

    // Redirect beats load-use and mult/div
    s_br = 1; s_mr = 1; s_ex_rt = 7; s_rs = 7; s_md = 1;
    step();
    chk("br_iff_lit", if_id_flush, 1);
    chk("br_pc_lit", pc_write, 1);
    set_idle();
    step();
    chk("br_flush_lit", flush_count, 1);
    chk("br_no_md_lit", md_busy, 0);

    // Mult/div pulse at T
    s_md = 1;
    step();
    set_idle();
    step();
    chk("md_t1_busy_lit", md_busy, 1);
    chk("md_t1_done_lit", md_done, 0);
    step();
    step();
    chk("md_t3_done_lit", md_done, 1);
    step();
    chk("md_t4_busy_lit", md_busy, 0);
    chk("md_t4_pc_lit", pc_write, 1);
    chk("md_stall_lit", stall_cycles, 4);

    // Load-use together with mult/div: stall first, then accept
    s_md = 1; s_mr = 1; s_ex_rt = 3; s_rt = 3; s_uses_rt = 1;
    step();
    chk("lumd_pc_lit", pc_write, 0);
    s_mr = 0;
    step();
    set_idle();
    step();
    chk("lumd_busy_lit", md_busy, 1);
    repeat (3) step();

    // Reset during second MD_WAIT cycle
    s_md = 1;
    step();
    set_idle();
    step();
    step();
    reset_n = 0;
    #1;
    chk("arst_busy_lit", md_busy, 0);
    chk("arst_done_lit", md_done, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    step();

    // Saturation with preloaded counters
    pre_stall = 1; pre_stall_v = 32'hFFFF_FFFD;
    s_mr = 1; s_ex_rt = 9; s_rs = 9;
    repeat (5) step();
    set_idle();
    step();
    chk("stall_sat_lit", stall_cycles, 32'hFFFF_FFFF);
    pre_flush = 1; pre_flush_v = 16'hFFFD;
    s_j = 1;
    repeat (5) step();
    set_idle();
    step();
    chk("flush_sat_lit", flush_count, 16'hFFFF);
    s_clr = 1;
    step();
    set_idle();
    step();
    chk("clr_stall_lit", stall_cycles, 0);
    chk("clr_flush_lit", flush_count, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_rs = 5'($urandom_range(0, 3));
      s_rt = 5'($urandom_range(0, 3));
      s_ex_rt = 5'($urandom_range(0, 3));
      s_uses_rt = ($urandom_range(0, 1) == 1);
      s_mr = ($urandom_range(0, 9) < 3);
      s_br = ($urandom_range(0, 19) < 2);
      s_j = ($urandom_range(0, 19) == 0);
      s_md = ($urandom_range(0, 19) < 3);
      s_clr = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
